// File: rtl/dragon_segment_tracker_pkg.sv
// Shared game definitions: grid/position widths, heading encodings and pos_t helpers.
// Used by dragon_segment_tracker (optional feature macro: SELF_COLLISION_EN) and dragon_head_stepper.
package dragon_segment_tracker_pkg;

    localparam int GRID_BITS = 4;
    localparam int POS_W     = 8;
    localparam int MAX_SEGS  = 7;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    function automatic logic [GRID_BITS-1:0] pos_row(input pos_t p);
        return p[POS_W-1:GRID_BITS];
    endfunction

    function automatic logic [GRID_BITS-1:0] pos_col(input pos_t p);
        return p[GRID_BITS-1:0];
    endfunction

    function automatic pos_t pos_pack(input logic [GRID_BITS-1:0] row,
                                      input logic [GRID_BITS-1:0] col);
        return {row, col};
    endfunction

    // Opposite headings differ only in the upper encoding bit.
    function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] req);
        return (cur ^ req) == 2'b10;
    endfunction

endpackage

// File: rtl/dragon_head_stepper.sv
// Combinational one-cell step of a grid position; row and col each wrap mod 16.
module dragon_head_stepper
    import dragon_segment_tracker_pkg::*;
(
    input  pos_t       pos_i,
    input  logic [1:0] dir_i,
    output pos_t       next_pos_o
);

    logic [GRID_BITS-1:0] row, col;

    always_comb begin
        row = pos_row(pos_i);
        col = pos_col(pos_i);
        case (dir_i)
            DIR_UP:    row = row - 4'd1;
            DIR_RIGHT: col = col + 4'd1;
            DIR_DOWN:  row = row + 4'd1;
            default:   col = col - 4'd1;
        endcase
        next_pos_o = pos_pack(row, col);
    end

endmodule

// File: rtl/dragon_segment_tracker.sv
// Dragon body owner: steps the head per move_tick, shifts the body, grows on request.
// Define SELF_COLLISION_EN to build the head-vs-body collision detector.
module dragon_segment_tracker
    import dragon_segment_tracker_pkg::*;
#(
    parameter int         MAX_SEGS  = 7,
    parameter logic [7:0] START_POS = 8'h00,
    parameter logic [1:0] START_DIR = 2'd1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  move_tick,
    input  logic                  halt,
    input  logic [1:0]            dir_req,
    input  logic                  grow_req,
    output logic [8*MAX_SEGS-1:0] dragonSegmentPositions,
    output logic [MAX_SEGS-1:0]   activeDragonSegments,
    output logic [7:0]            head_pos,
    output logic                  moved,
    output logic                  self_collision
);

    localparam int               LEN_W   = 3;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_SEGS);

    pos_t [MAX_SEGS-1:0] slot_q, slot_d;
    logic [MAX_SEGS-1:0] active_q, active_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          dir_q, dir_d;
    logic                grow_pend_q, grow_pend_d;
    logic                moved_q;
    logic                coll_q, coll_d;

    logic accept, grow_ok;
    pos_t next_head;

    assign accept  = move_tick & ~halt;
    // A same-cycle grow_req counts for this move; at full length it is dropped.
    assign grow_ok = (grow_pend_q | grow_req) & (len_q < LEN_MAX);

    dragon_head_stepper u_stepper (
        .pos_i      (slot_q[0]),
        .dir_i      (dir_q),
        .next_pos_o (next_head)
    );

    always_comb begin
        slot_d      = slot_q;
        active_d    = active_q;
        len_d       = len_q;
        grow_pend_d = grow_pend_q | grow_req;
        dir_d       = ((len_q > LEN_W'(1)) && is_reversal(dir_q, dir_req)) ? dir_q : dir_req;
        if (accept) begin
            grow_pend_d = 1'b0;
            slot_d[0]   = next_head;
            for (int i = 1; i < MAX_SEGS; i++) slot_d[i] = slot_q[i-1];
            if (grow_ok) begin
                len_d    = len_q + LEN_W'(1);
                active_d = (active_q << 1) | MAX_SEGS'(1);
            end
        end
    end

`ifdef SELF_COLLISION_EN
    logic [MAX_SEGS-1:0] chk_mask, hit;

    // The tail cell is vacated this move unless the body grows into it.
    assign chk_mask = grow_ok ? active_q : (active_q >> 1);

    for (genvar i = 0; i < MAX_SEGS; i++) begin : g_cmp
        assign hit[i] = chk_mask[i] & (slot_q[i] == next_head);
    end

    assign coll_d = accept & (|hit);
`else
    assign coll_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q      <= '0;
            slot_q[0]   <= START_POS;
            active_q    <= MAX_SEGS'(1);
            len_q       <= LEN_W'(1);
            dir_q       <= START_DIR;
            grow_pend_q <= 1'b0;
            moved_q     <= 1'b0;
            coll_q      <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            active_q    <= active_d;
            len_q       <= len_d;
            dir_q       <= dir_d;
            grow_pend_q <= grow_pend_d;
            moved_q     <= accept;
            coll_q      <= coll_d;
        end
    end

    assign dragonSegmentPositions = slot_q;
    assign activeDragonSegments   = active_q;
    assign head_pos               = slot_q[0];
    assign moved                  = moved_q;
    assign self_collision         = coll_q;

endmodule

// File: tb/tb_dragon_segment_tracker.sv
// Scoreboard bench for dragon_segment_tracker: a reference model pushes the expected
// image for every accepted move, popped and compared when moved pulses.
module tb_dragon_segment_tracker;

    localparam logic [1:0] UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3;
`ifdef SELF_COLLISION_EN
    localparam logic COLL_ON = 1'b1;
`else
    localparam logic COLL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        move_tick, halt, grow_req;
    logic [1:0]  dir_req;
    logic [55:0] bus;
    logic [6:0]  active;
    logic [7:0]  head_pos;
    logic        moved, self_collision;

    dragon_segment_tracker dut (
        .clk                    (clk),
        .reset                  (reset),
        .move_tick              (move_tick),
        .halt                   (halt),
        .dir_req                (dir_req),
        .grow_req               (grow_req),
        .dragonSegmentPositions (bus),
        .activeDragonSegments   (active),
        .head_pos               (head_pos),
        .moved                  (moved),
        .self_collision         (self_collision)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [55:0] bus;
        logic [6:0]  act;
        logic        coll;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_slot[7];
    int         m_len;
    logic [1:0] m_dir;
    logic       m_gp;
    logic       obs_coll;
    int         vec = 0;
    int         miss = 0;

    function automatic logic [7:0] step_pos(input logic [7:0] p, input logic [1:0] d);
        logic [3:0] r, c;
        r = p[7:4];
        c = p[3:0];
        case (d)
            UP:      r = r - 4'd1;
            DOWN:    r = r + 4'd1;
            RIGHT:   c = c + 4'd1;
            default: c = c - 4'd1;
        endcase
        return {r, c};
    endfunction

    function automatic logic [55:0] model_bus();
        logic [55:0] b;
        for (int i = 0; i < 7; i++) b[8*i +: 8] = m_slot[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_slot[i] = 8'h00;
        m_len = 1;
        m_dir = RIGHT;
        m_gp  = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of inputs, advance the model, then check the registered result.
    task automatic step(input logic mv, input logic hlt, input logic [1:0] dr, input logic gr);
        logic       acc, gok, hit;
        logic [7:0] nh;
        logic [1:0] ndir;
        exp_t       e, got;
        move_tick = mv;
        halt      = hlt;
        dir_req   = dr;
        grow_req  = gr;
        acc  = mv & ~hlt;
        gok  = (m_gp | gr) && (m_len < 7);
        nh   = step_pos(m_slot[0], m_dir);
        ndir = (m_len > 1 && dr == (m_dir ^ 2'b10)) ? m_dir : dr;
        hit  = 1'b0;
        for (int i = 0; i < m_len; i++)
            if ((i < m_len - 1 || gok) && m_slot[i] == nh) hit = 1'b1;
        if (acc) begin
            for (int i = 6; i > 0; i--) m_slot[i] = m_slot[i-1];
            m_slot[0] = nh;
            if (gok) m_len++;
            m_gp   = 1'b0;
            e.bus  = model_bus();
            e.act  = 7'((1 << m_len) - 1);
            e.coll = hit & COLL_ON;
            sb.push_back(e);
        end else if (gr) begin
            m_gp = 1'b1;
        end
        m_dir = ndir;
        @(posedge clk);
        #1;
        obs_coll = self_collision;
        vec++;
        if (moved !== acc) begin
            miss++;
            $display("FAIL moved: got %b want %b", moved, acc);
        end
        if (moved === 1'b1 && sb.size() > 0) begin
            e   = sb.pop_front();
            got = '{bus: bus, act: active, coll: self_collision};
            vec++;
            if (got !== e || head_pos !== e.bus[7:0]) begin
                miss++;
                $display("FAIL move_image: got bus=%h act=%h coll=%b head=%h want bus=%h act=%h coll=%b",
                         bus, active, self_collision, head_pos, e.bus, e.act, e.coll);
            end
        end else if (self_collision !== 1'b0) begin
            vec++;
            miss++;
            $display("FAIL coll_idle: got %b want 0", self_collision);
        end
    endtask

    task automatic do_reset();
        move_tick = 1'b0;
        halt      = 1'b0;
        grow_req  = 1'b0;
        dir_req   = RIGHT;
        reset     = 1'b0;
        #12;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if (bus !== 56'h0 || active !== 7'h01 || moved !== 1'b0 || self_collision !== 1'b0) begin
            miss++;
            $display("FAIL reset_image: got bus=%h act=%h moved=%b coll=%b want bus=0 act=01 moved=0 coll=0",
                     bus, active, moved, self_collision);
        end
        step(1, 0, RIGHT, 0);
        vec++;
        if (head_pos !== 8'h01) begin
            miss++;
            $display("FAIL first_move: got %h want 01", head_pos);
        end
        step(0, 0, RIGHT, 0);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 0, RIGHT, 0);
        vec++;
        if (head_pos !== 8'h0F) begin
            miss++;
            $display("FAIL pre_wrap: got %h want 0F", head_pos);
        end
        step(1, 0, RIGHT, 0);
        vec++;
        if (head_pos !== 8'h00) begin
            miss++;
            $display("FAIL wrap_col: got %h want 00", head_pos);
        end
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, RIGHT, 0);
        step(0, 0, UP, 0);
        step(1, 0, UP, 0);
        vec++;
        if (head_pos !== 8'hF5) begin
            miss++;
            $display("FAIL wrap_row: got %h want F5", head_pos);
        end
    endtask

    task automatic test_grow();
        do_reset();
        step(1, 0, RIGHT, 1);
        vec++;
        if (active !== 7'h03 || bus[7:0] !== 8'h01 || bus[15:8] !== 8'h00) begin
            miss++;
            $display("FAIL grow_first: got act=%h s0=%h s1=%h want act=03 s0=01 s1=00",
                     active, bus[7:0], bus[15:8]);
        end
        for (int i = 0; i < 6; i++) step(1, 0, RIGHT, 1);
        vec++;
        if (active !== 7'h7F) begin
            miss++;
            $display("FAIL grow_full: got %h want 7F", active);
        end
        step(1, 0, RIGHT, 1);
        vec++;
        if (active !== 7'h7F) begin
            miss++;
            $display("FAIL grow_sat: got %h want 7F", active);
        end
        // Pending grow: two pulses absorbed into one, consumed by the next move only.
        do_reset();
        step(0, 0, RIGHT, 1);
        step(0, 0, RIGHT, 1);
        step(1, 0, RIGHT, 0);
        step(1, 0, RIGHT, 0);
        vec++;
        if (active !== 7'h03) begin
            miss++;
            $display("FAIL grow_pend: got %h want 03", active);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        step(1, 0, RIGHT, 1);
        step(1, 0, RIGHT, 1);
        step(0, 0, LEFT, 0);
        step(1, 0, LEFT, 0);
        vec++;
        if (head_pos !== 8'h03) begin
            miss++;
            $display("FAIL rev_len3: got %h want 03", head_pos);
        end
        do_reset();
        step(1, 0, RIGHT, 0);
        step(1, 0, RIGHT, 0);
        step(0, 0, LEFT, 0);
        step(1, 0, LEFT, 0);
        vec++;
        if (head_pos !== 8'h01) begin
            miss++;
            $display("FAIL rev_len1: got %h want 01", head_pos);
        end
    endtask

    task automatic test_halt();
        do_reset();
        step(1, 0, RIGHT, 1);
        step(1, 0, RIGHT, 0);
        for (int i = 0; i < 4; i++) step(1, 1, RIGHT, 0);
        vec++;
        if (bus !== {40'h0, 8'h01, 8'h02} || active !== 7'h03) begin
            miss++;
            $display("FAIL halt_hold: got bus=%h act=%h want bus=0102 act=03", bus, active);
        end
        // Reset lands while a tick is presented: nothing of that move may survive.
        step(1, 0, RIGHT, 0);
        move_tick = 1'b1;
        #2 reset = 1'b0;
        #10 reset = 1'b1;
        move_tick = 1'b0;
        model_reset();
        vec++;
        if (bus !== 56'h0 || active !== 7'h01 || moved !== 1'b0) begin
            miss++;
            $display("FAIL reset_mid: got bus=%h act=%h moved=%b want bus=0 act=01 moved=0",
                     bus, active, moved);
        end
        @(posedge clk);
        #1;
        step(1, 0, RIGHT, 0);
        vec++;
        if (head_pos !== 8'h01) begin
            miss++;
            $display("FAIL post_reset_move: got %h want 01", head_pos);
        end
    endtask

    task automatic run_square(input int grows);
        do_reset();
        for (int i = 0; i < grows; i++) step(1, 0, RIGHT, 1);
        step(0, 0, DOWN, 0);  step(1, 0, DOWN, 0);
        step(0, 0, RIGHT, 0); step(1, 0, RIGHT, 0);
        step(0, 0, UP, 0);    step(1, 0, UP, 0);
        step(0, 0, LEFT, 0);  step(1, 0, LEFT, 0);
    endtask

    task automatic test_self_collision();
        run_square(4);
        vec++;
        if (obs_coll !== COLL_ON) begin
            miss++;
            $display("FAIL coll_len5: got %b want %b", obs_coll, COLL_ON);
        end
        run_square(3);
        vec++;
        if (obs_coll !== 1'b0) begin
            miss++;
            $display("FAIL coll_len4: got %b want 0", obs_coll);
        end
        step(0, 0, LEFT, 0);
        vec++;
        if (sb.size() != 0) begin
            miss++;
            $display("FAIL sb_drain: got %0d want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_grow();
        test_reversal();
        test_halt();
        test_self_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
